pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, holds the pipe during multi-cycle LSU and MDU transactions, and squashes wrong-path instructions on a taken branch or jump.
- Generates per-stage stall and flush enables consumed by the stage registers, plus forwarding selects for the EX operands.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 64 ++++++
 rtl/pipe_hazard_ctrl_fwd_sel_unit.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and state encoding for the hazard controller
package pipe_hazard_ctrl_pkg;

  localparam int PHC_XLEN = 64;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic [1:0] {
    PHC_RUN = 2'd0,
    PHC_LSU = 2'd1,
    PHC_MDU = 2'd2
  } phc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN   = PHC_XLEN,
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_use;
  logic              id_rs2_use;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wben;
  logic              ex_is_load;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_wben;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_wben;
  logic              ex_mdu_start;
  logic              mdu_done;
  logic              mem_lsu_req;
  logic              lsu_ack;
  logic              ex_redirect;
  logic [XLEN-1:0]   ex_redirect_pc;

  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              stall_mem;
  logic              flush_id;
  logic              flush_ex;
  logic              flush_wb;
  logic [1:0]        fwd_rs1_sel;
  logic [1:0]        fwd_rs2_sel;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              lsu_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_use, id_rs2_use,
    output ex_rd, ex_wben, ex_is_load, mem_rd, mem_wben, wb_rd, wb_wben,
    output ex_mdu_start, mdu_done, mem_lsu_req, lsu_ack,
    output ex_redirect, ex_redirect_pc,
    input  stall_if, stall_id, stall_ex, stall_mem,
    input  flush_id, flush_ex, flush_wb,
    input  fwd_rs1_sel, fwd_rs2_sel,
    input  redirect_valid, redirect_pc, lsu_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_use, id_rs2_use,
    input  ex_rd, ex_wben, ex_is_load, mem_rd, mem_wben, wb_rd, wb_wben,
    input  ex_mdu_start, mdu_done, mem_lsu_req, lsu_ack,
    input  ex_redirect, ex_redirect_pc,
    output stall_if, stall_id, stall_ex, stall_mem,
    output flush_id, flush_ex, flush_wb,
    output fwd_rs1_sel, fwd_rs2_sel,
    output redirect_valid, redirect_pc, lsu_timeout, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
// rtl/pipe_hazard_ctrl_fwd_sel_unit.sv - per-operand forwarding source comparator
module fwd_sel_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
)
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wben,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wben,
  output logic [1:0]        sel
);

  // x0 is hardwired zero, so a write to it must never be forwarded.
  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (mem_wben && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_wben && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding sequencer for the 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN   = PHC_XLEN,
  parameter int REG_AW = 5,
  parameter int TMO_W  = 8,
  parameter int PERF_W = 32
)
(
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  phc_state_e        state_q;
  phc_state_e        state_d;
  logic              pend_q;
  logic [XLEN-1:0]   pend_pc_q;
  logic [TMO_W-1:0]  wdog_q;
  logic              tmo_q;
  logic [PERF_W-1:0] perf_q;

  logic              load_use;
  logic              stall_if_c;
  logic              stall_id_c;
  logic              stall_ex_c;
  logic              stall_mem_c;
  logic              flush_id_c;
  logic              flush_ex_c;
  logic              flush_wb_c;
  logic              redirect_valid_c;
  logic [XLEN-1:0]   redirect_pc_c;

  always_comb begin
    load_use = hz.ex_is_load && hz.ex_wben && (hz.ex_rd != '0) &&
               ((hz.id_rs1_use && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_rs2_use && (hz.id_rs2 == hz.ex_rd)));
  end

  always_comb begin
    state_d          = state_q;
    stall_if_c       = 1'b0;
    stall_id_c       = 1'b0;
    stall_ex_c       = 1'b0;
    stall_mem_c      = 1'b0;
    flush_id_c       = 1'b0;
    flush_ex_c       = 1'b0;
    flush_wb_c       = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;

    unique case (state_q)
      PHC_RUN: begin
        if (hz.mem_lsu_req && !hz.lsu_ack) begin
          state_d = PHC_LSU;
        end else if (hz.ex_mdu_start && !hz.mdu_done) begin
          state_d = PHC_MDU;
        end
        // A redirect held back by a stall is replayed before anything new.
        if (pend_q) begin
          redirect_valid_c = 1'b1;
          redirect_pc_c    = pend_pc_q;
          flush_id_c       = 1'b1;
          flush_ex_c       = 1'b1;
        end else if (hz.ex_redirect) begin
          redirect_valid_c = 1'b1;
          redirect_pc_c    = hz.ex_redirect_pc;
          flush_id_c       = 1'b1;
          flush_ex_c       = 1'b1;
        end else if (load_use) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          flush_ex_c = 1'b1;
        end
      end
      PHC_LSU: begin
        if (hz.lsu_ack) begin
          state_d = PHC_RUN;
        end
        stall_if_c  = 1'b1;
        stall_id_c  = 1'b1;
        stall_ex_c  = 1'b1;
        stall_mem_c = 1'b1;
        flush_wb_c  = 1'b1;
      end
      PHC_MDU: begin
        if (hz.mdu_done) begin
          state_d = PHC_RUN;
        end
        // EX/MEM keeps advancing; EX gates its own wben so MEM sees bubbles.
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        stall_ex_c = 1'b1;
      end
      default: begin
        state_d = PHC_RUN;
      end
    endcase

    if (rst) begin
      stall_if_c       = 1'b0;
      stall_id_c       = 1'b0;
      stall_ex_c       = 1'b0;
      stall_mem_c      = 1'b0;
      flush_id_c       = 1'b0;
      flush_ex_c       = 1'b0;
      flush_wb_c       = 1'b0;
      redirect_valid_c = 1'b0;
      redirect_pc_c    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PHC_RUN;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      wdog_q    <= '0;
      tmo_q     <= 1'b0;
      perf_q    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q != PHC_RUN) begin
        if (hz.ex_redirect && !pend_q) begin
          pend_q    <= 1'b1;
          pend_pc_q <= hz.ex_redirect_pc;
        end
      end else if (pend_q) begin
        pend_q <= 1'b0;
      end

      if ((state_q == PHC_RUN) && (state_d == PHC_LSU)) begin
        wdog_q <= '0;
      end else if ((state_q == PHC_LSU) && (wdog_q != '1)) begin
        wdog_q <= wdog_q + TMO_W'(1);
      end

      if (wdog_q == '1) begin
        tmo_q <= 1'b1;
      end

      if (stall_if_c) begin
        perf_q <= perf_q + PERF_W'(1);
      end
    end
  end

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .rs       (hz.id_rs1),
    .mem_rd   (hz.mem_rd),
    .mem_wben (hz.mem_wben),
    .wb_rd    (hz.wb_rd),
    .wb_wben  (hz.wb_wben),
    .sel      (hz.fwd_rs1_sel)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .rs       (hz.id_rs2),
    .mem_rd   (hz.mem_rd),
    .mem_wben (hz.mem_wben),
    .wb_rd    (hz.wb_rd),
    .wb_wben  (hz.wb_wben),
    .sel      (hz.fwd_rs2_sel)
  );

  assign hz.stall_if       = stall_if_c;
  assign hz.stall_id       = stall_id_c;
  assign hz.stall_ex       = stall_ex_c;
  assign hz.stall_mem      = stall_mem_c;
  assign hz.flush_id       = flush_id_c;
  assign hz.flush_ex       = flush_ex_c;
  assign hz.flush_wb       = flush_wb_c;
  assign hz.redirect_valid = redirect_valid_c;
  assign hz.redirect_pc    = redirect_pc_c;
  assign hz.lsu_timeout    = tmo_q | (wdog_q == '1);
  assign hz.stall_cycles   = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_LSU  = 7'b1111001;
  localparam logic [6:0] C_MDU  = 7'b1110000;
  localparam logic [6:0] C_RDR  = 7'b0000110;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic [3:0]  fwd;
    logic        rv;
    logic [63:0] pc;
    logic        tmo;
    logic [31:0] perf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_perf;
  exp_t sb[$];
  exp_t e;

  pipe_hazard_ctrl_if #(.XLEN(64), .REG_AW(5), .PERF_W(32)) hz ();

  pipe_hazard_ctrl #(.XLEN(64), .REG_AW(5), .TMO_W(4), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check_val(input string tag, input string fld, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, fld, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val(e.tag, "ctl", 64'({hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                                   hz.flush_id, hz.flush_ex, hz.flush_wb}), 64'(e.ctl));
      check_val(e.tag, "fwd", 64'({hz.fwd_rs1_sel, hz.fwd_rs2_sel}), 64'(e.fwd));
      check_val(e.tag, "redirect_valid", 64'(hz.redirect_valid), 64'(e.rv));
      if (e.rv) check_val(e.tag, "redirect_pc", hz.redirect_pc, e.pc);
      check_val(e.tag, "lsu_timeout", 64'(hz.lsu_timeout), 64'(e.tmo));
      check_val(e.tag, "stall_cycles", 64'(hz.stall_cycles), 64'(e.perf));
    end
  end

  task automatic idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_use = 1'b0; hz.id_rs2_use = 1'b0;
    hz.ex_rd = '0; hz.ex_wben = 1'b0; hz.ex_is_load = 1'b0;
    hz.mem_rd = '0; hz.mem_wben = 1'b0; hz.wb_rd = '0; hz.wb_wben = 1'b0;
    hz.ex_mdu_start = 1'b0; hz.mdu_done = 1'b0;
    hz.mem_lsu_req = 1'b0; hz.lsu_ack = 1'b0;
    hz.ex_redirect = 1'b0; hz.ex_redirect_pc = '0;
  endtask

  // Push the expectation for the cycle whose inputs are now applied, then advance.
  task automatic cyc(input string tag, input logic [6:0] ctl, input logic [3:0] fwd,
                     input logic rv, input logic [63:0] pc, input logic tmo);
    exp_t x;
    x.tag = tag; x.ctl = ctl; x.fwd = fwd; x.rv = rv; x.pc = pc; x.tmo = tmo;
    x.perf = 32'(exp_perf);
    sb.push_back(x);
    if (rst) exp_perf = 0;
    else if (ctl[6]) exp_perf++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_perf = 0;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cyc("reset", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    rst = 1'b0;
    cyc("idle", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.ex_wben = 1'b1; hz.id_rs1 = 5'd5; hz.id_rs1_use = 1'b1;
    cyc("lu_stall", C_LU, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle(); hz.mem_rd = 5'd5; hz.mem_wben = 1'b1; hz.id_rs1 = 5'd5; hz.id_rs1_use = 1'b1;
    cyc("lu_fwd_mem", C_NONE, 4'b0100, 1'b0, 64'h0, 1'b0);
    idle(); hz.wb_rd = 5'd5; hz.wb_wben = 1'b1; hz.id_rs1 = 5'd5;
    cyc("fwd_wb", C_NONE, 4'b1000, 1'b0, 64'h0, 1'b0);
    idle(); hz.ex_is_load = 1'b1; hz.ex_wben = 1'b1; hz.ex_rd = 5'd9; hz.id_rs2 = 5'd9;
    cyc("lu_unused_rs", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle(); hz.ex_is_load = 1'b1; hz.ex_wben = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1_use = 1'b1;
    cyc("lu_x0", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle(); hz.mem_rd = 5'd7; hz.wb_rd = 5'd7; hz.mem_wben = 1'b1; hz.wb_wben = 1'b1; hz.id_rs2 = 5'd7;
    cyc("fwd_prio", C_NONE, 4'b0001, 1'b0, 64'h0, 1'b0);
    hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.id_rs2 = 5'd0;
    cyc("fwd_x0", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    idle(); hz.ex_is_load = 1'b1; hz.ex_wben = 1'b1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3; hz.id_rs1_use = 1'b1;
    hz.ex_redirect = 1'b1; hz.ex_redirect_pc = 64'h1234;
    cyc("rdr_over_lu", C_RDR, 4'b0000, 1'b1, 64'h1234, 1'b0);
    idle();
    cyc("rdr_clear", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    rst = 1'b1;
    cyc("rst_perf", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    rst = 1'b0;
    hz.mem_lsu_req = 1'b1;
    cyc("lsu_req", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    cyc("lsu_w1", C_LSU, 4'b0000, 1'b0, 64'h0, 1'b0);
    cyc("lsu_w2", C_LSU, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.lsu_ack = 1'b1;
    cyc("lsu_ack", C_LSU, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle();
    cyc("lsu_done", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.mem_lsu_req = 1'b1; hz.lsu_ack = 1'b1;
    cyc("lsu_fast", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle();
    cyc("lsu_fast_run", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    hz.mem_lsu_req = 1'b1;
    cyc("rl_req", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.ex_redirect = 1'b1; hz.ex_redirect_pc = 64'h8000_0100;
    cyc("rl_w1", C_LSU, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.ex_redirect_pc = 64'hdead;
    cyc("rl_w2", C_LSU, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.ex_redirect = 1'b0; hz.lsu_ack = 1'b1;
    cyc("rl_ack", C_LSU, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle();
    cyc("rl_replay", C_RDR, 4'b0000, 1'b1, 64'h8000_0100, 1'b0);
    cyc("rl_after", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    hz.ex_mdu_start = 1'b1;
    cyc("mdu_start", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.ex_mdu_start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mdu_wait", C_MDU, 4'b0000, 1'b0, 64'h0, 1'b0);
    hz.mdu_done = 1'b1;
    cyc("mdu_done", C_MDU, 4'b0000, 1'b0, 64'h0, 1'b0);
    idle();
    cyc("mdu_end", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    hz.mem_lsu_req = 1'b1;
    cyc("wd_req", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("wd_wait", C_LSU, 4'b0000, 1'b0, 64'h0, (i >= 15));
    rst = 1'b1;
    cyc("wd_rst", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b1);
    rst = 1'b0;
    idle();
    cyc("wd_clear", C_NONE, 4'b0000, 1'b0, 64'h0, 1'b0);

    @(negedge clk);
    check_val("end", "sb_left", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
